// File: rtl/bsg_gatestack_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bsg_gatestack_ctrl_pkg
//   Shared types and helpers for the gated-flop stack write controller.
//   Contents:
//     gs_state_e    - controller FSM state encoding
//     gs_cnt_width  - width of the phase down-counter, derived from the
//                     setup and pulse lengths
// -----------------------------------------------------------------------------
package bsg_gatestack_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } gs_state_e;

    // ceil(log2(max(setup, pulse) + 1)), never narrower than one bit
    function automatic int gs_cnt_width(input int setup_cycles, input int pulse_cycles);
        int max_cycles;
        int w;
        max_cycles = (setup_cycles > pulse_cycles) ? setup_cycles : pulse_cycles;
        w = $clog2(max_cycles + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bsg_gatestack_ctrl_rr_arb.sv
// -----------------------------------------------------------------------------
// bsg_gatestack_rr_arb
//   Two-way round-robin arbiter for the gate-stack write port.
//   Ports:
//     clk_i      - clock
//     reset_n_i  - asynchronous active-low reset; pointer returns to A
//     v[1:0]     - request valids, bit 0 = requester A, bit 1 = requester B
//     yumi       - a granted request was consumed this cycle
//     grant[1:0] - one-hot grant (all zero when nothing is valid)
// -----------------------------------------------------------------------------
module bsg_gatestack_rr_arb (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic [1:0] v,
    input  logic       yumi,
    output logic [1:0] grant
);

    // ptr_r = 0 favours A, 1 favours B when both are valid
    logic ptr_r;

    always_comb begin
        grant = 2'b00;
        unique case (v)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr_r ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // After a consumed grant the other requester gets priority.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_r <= 1'b0;
        end else if (yumi) begin
            ptr_r <= grant[0];
        end
    end

endmodule

// File: rtl/bsg_gatestack_ctrl.sv
// -----------------------------------------------------------------------------
// bsg_gatestack_ctrl
//   Write controller for a stack of clock-gated flops. Two requesters share
//   the port through a round-robin arbiter; each accepted write drives the
//   masked lanes of data_o, waits setup_cycles_p, pulses strobe_o on those
//   lanes for pulse_cycles_p, then idles one cycle with strobe low.
//
//   Parameters:
//     width_p        - number of gated-flop lanes
//     setup_cycles_p - data-to-strobe setup cycles (>= 1)
//     pulse_cycles_p - strobe high cycles (>= 1)
//   Ports:
//     clk_i, reset_n_i       - clock, asynchronous active-low reset
//     a_v_i/a_mask_i/a_data_i, a_ready_o - requester A write request
//     b_v_i/b_mask_i/b_data_i, b_ready_o - requester B write request
//     data_o                 - data to the gated flops
//     strobe_o               - per-lane gated clock (registered)
//     busy_o                 - high whenever the FSM is not IDLE
//     shadow_o               - only with BSG_GATESTACK_CTRL_SHADOW_EN:
//                              copy of what the flops are expected to hold
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | ready to arbitrate; handshake latches mask/data
//   ST_SETUP | data_o stable on masked lanes, strobe low
//   ST_PULSE | strobe_o = latched mask, data_o unchanged
//   ST_HOLD  | strobe low for one cycle before the next request
// -----------------------------------------------------------------------------
module bsg_gatestack_ctrl
    import bsg_gatestack_ctrl_pkg::*;
#(
    parameter int width_p        = 16,
    parameter int setup_cycles_p = 1,
    parameter int pulse_cycles_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,

    input  logic               a_v_i,
    input  logic [width_p-1:0] a_mask_i,
    input  logic [width_p-1:0] a_data_i,
    output logic               a_ready_o,

    input  logic               b_v_i,
    input  logic [width_p-1:0] b_mask_i,
    input  logic [width_p-1:0] b_data_i,
    output logic               b_ready_o,

    output logic [width_p-1:0] data_o,
    output logic [width_p-1:0] strobe_o,
    output logic               busy_o
`ifdef BSG_GATESTACK_CTRL_SHADOW_EN
   ,output logic [width_p-1:0] shadow_o
`endif
);

    localparam int cnt_width_lp = gs_cnt_width(setup_cycles_p, pulse_cycles_p);

    // Down-counter reload values: the phase ends when the counter reads zero.
    localparam logic [cnt_width_lp-1:0] setup_load_lp = cnt_width_lp'(setup_cycles_p - 1);
    localparam logic [cnt_width_lp-1:0] pulse_load_lp = cnt_width_lp'(pulse_cycles_p - 1);
    localparam logic [cnt_width_lp-1:0] cnt_one_lp    = cnt_width_lp'(1);

    gs_state_e               state_r;
    logic [cnt_width_lp-1:0] cnt_r;
    logic [width_p-1:0]      mask_r;

    logic [1:0]              grant;
    logic                    idle;
    logic                    hs;
    logic [width_p-1:0]      sel_mask;
    logic [width_p-1:0]      sel_data;

    bsg_gatestack_rr_arb u_arb (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v         ({b_v_i, a_v_i}),
        .yumi      (hs),
        .grant     (grant)
    );

    assign idle = (state_r == ST_IDLE);

    // Ready is qualified by reset so nothing handshakes while reset is held,
    // yet the first edge after release can already accept a request.
    assign a_ready_o = reset_n_i & idle & grant[0];
    assign b_ready_o = reset_n_i & idle & grant[1];

    assign hs = (a_v_i & a_ready_o) | (b_v_i & b_ready_o);

    assign sel_mask = grant[1] ? b_mask_i : a_mask_i;
    assign sel_data = grant[1] ? b_data_i : a_data_i;

    // data_o only moves on the handshake edge and strobe_o only on the
    // SETUP->PULSE and PULSE->HOLD edges, so they never change together.
    // data_o itself is the latch for the request data.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            mask_r   <= '0;
            data_o   <= '0;
            strobe_o <= '0;
            busy_o   <= 1'b0;
        end else begin
            unique case (state_r)
                ST_IDLE: begin
                    if (hs) begin
                        mask_r <= sel_mask;
                        if (|sel_mask) begin
                            state_r <= ST_SETUP;
                            busy_o  <= 1'b1;
                            cnt_r   <= setup_load_lp;
                            data_o  <= (data_o & ~sel_mask) | (sel_data & sel_mask);
                        end
                    end
                end
                ST_SETUP: begin
                    if (cnt_r == '0) begin
                        state_r  <= ST_PULSE;
                        strobe_o <= mask_r;
                        cnt_r    <= pulse_load_lp;
                    end else begin
                        cnt_r <= cnt_r - cnt_one_lp;
                    end
                end
                ST_PULSE: begin
                    if (cnt_r == '0) begin
                        state_r  <= ST_HOLD;
                        strobe_o <= '0;
                    end else begin
                        cnt_r <= cnt_r - cnt_one_lp;
                    end
                end
                ST_HOLD: begin
                    state_r <= ST_IDLE;
                    busy_o  <= 1'b0;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    strobe_o <= '0;
                    busy_o   <= 1'b0;
                end
            endcase
        end
    end

`ifdef BSG_GATESTACK_CTRL_SHADOW_EN
    // Captured on the last strobe-high cycle: the flops have been clocked
    // with data_o on the masked lanes by then.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            shadow_o <= '0;
        end else if ((state_r == ST_PULSE) && (cnt_r == '0)) begin
            shadow_o <= (shadow_o & ~mask_r) | (data_o & mask_r);
        end
    end
`endif

endmodule
